// File: rtl/tmr_sum_voter.sv
// Majority voter for three redundant adder lanes with per-lane fault tracking,
// TMR -> DMR degradation, and a registered valid/ready output stage.
module tmr_sum_voter #(
    parameter int WIDTH      = 4,
    parameter int FAIL_LIMIT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_a,
    input  logic [WIDTH-1:0] sum_b,
    input  logic [WIDTH-1:0] sum_c,
    input  logic             cout_a,
    input  logic             cout_b,
    input  logic             cout_c,
    input  logic             clear_faults,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_corrected,
    output logic             out_uncorrectable,
    output logic [2:0]       lane_faulty,
    output logic [CNT_W-1:0] err_cnt_a,
    output logic [CNT_W-1:0] err_cnt_b,
    output logic [CNT_W-1:0] err_cnt_c
);

    localparam int LW = WIDTH + 1;
    localparam logic [3:0] LIMIT = 4'(FAIL_LIMIT);

    typedef enum logic {S_TMR, S_DMR} state_t;

    state_t                state, state_nx;
    logic [2:0]            faulty_nx;
    logic [LW-1:0]         w [3];
    logic [3:0]            consec [3];
    logic [3:0]            consec_nx [3];
    logic [CNT_W-1:0]      err [3];
    logic [CNT_W-1:0]      err_nx [3];
    logic [LW-1:0]         vote;
    logic                  corr, unc, accept, found;
    logic [2:0]            mis;
    logic [1:0]            h0, h1;

    assign w[0] = {cout_a, sum_a};
    assign w[1] = {cout_b, sum_b};
    assign w[2] = {cout_c, sum_c};

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign err_cnt_a = err[0];
    assign err_cnt_b = err[1];
    assign err_cnt_c = err[2];

    always_comb begin
        state_nx  = state;
        faulty_nx = lane_faulty;
        consec_nx = consec;
        err_nx    = err;
        vote      = '0;
        corr      = 1'b0;
        unc       = 1'b0;
        mis       = '0;
        found     = 1'b0;
        h0        = 2'd0;
        h1        = 2'd1;
        case (state)
            S_TMR: begin
                vote = (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
                for (int unsigned i = 0; i < 3; i++) mis[i] = (w[i] != vote);
                corr = |mis;
                if (accept) begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (mis[i]) begin
                            if (err[i] != '1) err_nx[i] = err[i] + CNT_W'(1);
                            consec_nx[i] = consec[i] + 4'd1;
                        end else begin
                            consec_nx[i] = '0;
                        end
                    end
                    // simultaneous limit hits: only the lowest-index lane is retired
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (!found && consec_nx[i] == LIMIT) begin
                            faulty_nx[i] = 1'b1;
                            found        = 1'b1;
                        end
                    end
                    if (found) begin
                        for (int unsigned i = 0; i < 3; i++) consec_nx[i] = '0;
                        state_nx = S_DMR;
                    end
                end
            end
            S_DMR: begin
                if (lane_faulty[0]) begin
                    h0 = 2'd1;
                    h1 = 2'd2;
                end else if (lane_faulty[1]) begin
                    h0 = 2'd0;
                    h1 = 2'd2;
                end
                vote = w[h0];
                if (w[h0] != w[h1]) begin
                    unc = 1'b1;
                    if (accept) begin
                        if (err[h0] != '1) err_nx[h0] = err[h0] + CNT_W'(1);
                        if (err[h1] != '1) err_nx[h1] = err[h1] + CNT_W'(1);
                    end
                end
                for (int unsigned i = 0; i < 3; i++) consec_nx[i] = '0;
            end
        endcase
        if (clear_faults) begin
            state_nx  = S_TMR;
            faulty_nx = '0;
            for (int unsigned i = 0; i < 3; i++) begin
                consec_nx[i] = '0;
                err_nx[i]    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_TMR;
            lane_faulty       <= '0;
            out_valid         <= 1'b0;
            out_sum           <= '0;
            out_cout          <= 1'b0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                consec[i] <= '0;
                err[i]    <= '0;
            end
        end else begin
            state       <= state_nx;
            lane_faulty <= faulty_nx;
            consec      <= consec_nx;
            err         <= err_nx;
            if (accept) begin
                out_valid         <= 1'b1;
                out_sum           <= vote[WIDTH-1:0];
                out_cout          <= vote[WIDTH];
                out_corrected     <= corr;
                out_uncorrectable <= unc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tmr_sum_voter.sv
// Bench for tmr_sum_voter: directed scenarios plus randomized traffic checked
// against a lane-counting reference model.
module tb_tmr_sum_voter;

    localparam int W  = 4;
    localparam int FL = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, clear_faults, out_valid, out_ready;
    logic [W-1:0]  sum_a, sum_b, sum_c, out_sum;
    logic          cout_a, cout_b, cout_c, out_cout, out_corrected, out_uncorrectable;
    logic [2:0]    lane_faulty;
    logic [CW-1:0] err_cnt_a, err_cnt_b, err_cnt_c;

    always #5 clk = ~clk;

    tmr_sum_voter #(.WIDTH(W), .FAIL_LIMIT(FL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sum_a(sum_a), .sum_b(sum_b), .sum_c(sum_c),
        .cout_a(cout_a), .cout_b(cout_b), .cout_c(cout_c),
        .clear_faults(clear_faults), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_corrected(out_corrected),
        .out_uncorrectable(out_uncorrectable), .lane_faulty(lane_faulty),
        .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c)
    );

    int total = 0;
    int bad   = 0;

    // reference model state: faulty lane index (-1 = full redundancy)
    int m_bad;
    int m_con [3];
    int m_err [3];
    int m_valid, m_sum, m_cout, m_corr, m_unc;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bad = -1;
        for (int i = 0; i < 3; i++) begin
            m_con[i] = 0;
            m_err[i] = 0;
        end
        m_valid = 0; m_sum = 0; m_cout = 0; m_corr = 0; m_unc = 0;
    endtask

    function automatic int inc_sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic model_cycle(input bit iv, input int wd [3], input bit ordy, input bit clr);
        int v, ones, hit;
        int hl [2];
        int corr, unc;
        bit acc;
        acc = iv && (!m_valid || ordy);
        v = 0; corr = 0; unc = 0;
        if (m_bad < 0) begin
            for (int b = 0; b < W + 1; b++) begin
                ones = 0;
                for (int l = 0; l < 3; l++) ones += (wd[l] >> b) & 1;
                if (ones >= 2) v += (1 << b);
            end
            for (int l = 0; l < 3; l++) if (wd[l] != v) corr = 1;
            if (acc) begin
                for (int l = 0; l < 3; l++) begin
                    if (wd[l] != v) begin
                        m_err[l] = inc_sat(m_err[l]);
                        m_con[l]++;
                    end else m_con[l] = 0;
                end
                hit = -1;
                for (int l = 2; l >= 0; l--) if (m_con[l] == FL) hit = l;
                if (hit >= 0) begin
                    m_bad = hit;
                    for (int l = 0; l < 3; l++) m_con[l] = 0;
                end
            end
        end else begin
            hl[0] = (m_bad == 0) ? 1 : 0;
            hl[1] = (m_bad == 2) ? 1 : 2;
            v = wd[hl[0]];
            if (wd[hl[0]] != wd[hl[1]]) begin
                unc = 1;
                if (acc) begin
                    m_err[hl[0]] = inc_sat(m_err[hl[0]]);
                    m_err[hl[1]] = inc_sat(m_err[hl[1]]);
                end
            end
        end
        if (acc) begin
            m_valid = 1;
            m_sum   = v % (1 << W);
            m_cout  = v >> W;
            m_corr  = corr;
            m_unc   = unc;
        end else if (ordy) m_valid = 0;
        if (clr) begin
            m_bad = -1;
            for (int l = 0; l < 3; l++) begin
                m_con[l] = 0;
                m_err[l] = 0;
            end
        end
    endtask

    task automatic check_all();
        cmp("out_valid", out_valid, m_valid);
        cmp("lane_faulty", lane_faulty, (m_bad < 0) ? 0 : (1 << m_bad));
        cmp("err_cnt_a", err_cnt_a, m_err[0]);
        cmp("err_cnt_b", err_cnt_b, m_err[1]);
        cmp("err_cnt_c", err_cnt_c, m_err[2]);
        if (m_valid != 0) begin
            cmp("out_sum", out_sum, m_sum);
            cmp("out_cout", out_cout, m_cout);
            cmp("out_corrected", out_corrected, m_corr);
            cmp("out_uncorrectable", out_uncorrectable, m_unc);
        end
    endtask

    // called at a falling edge; returns at the following falling edge
    task automatic step(input bit iv, input int wa, input int wb, input int wc,
                        input bit ordy, input bit clr);
        int wd [3];
        wd[0] = wa; wd[1] = wb; wd[2] = wc;
        in_valid     = iv;
        {cout_a, sum_a} = 5'(wa);
        {cout_b, sum_b} = 5'(wb);
        {cout_c, sum_c} = 5'(wc);
        out_ready    = ordy;
        clear_faults = clr;
        #1;
        cmp("in_ready", in_ready, (!m_valid || ordy) ? 1 : 0);
        model_cycle(iv, wd, ordy, clr);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        cmp("rst_out_valid", out_valid, 0);
        cmp("rst_lane_faulty", lane_faulty, 0);
        cmp("rst_err_c", err_cnt_c, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wa, wb, wc, base, r, held;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear_faults = 1'b0;
        sum_a = '0; sum_b = '0; sum_c = '0; cout_a = 1'b0; cout_b = 1'b0; cout_c = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        cmp("reset_out_valid", out_valid, 0);
        cmp("reset_out_sum", out_sum, 0);
        cmp("reset_err_a", err_cnt_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // clean transaction
        step(1, 'h0A, 'h0A, 'h0A, 1, 0);
        cmp("lit_clean_sum", out_sum, 'hA);
        cmp("lit_clean_corr", out_corrected, 0);

        // single-lane error outvoted
        step(1, 'h05, 'h05, 'h14, 1, 0);
        cmp("lit_corr_sum", out_sum, 5);
        cmp("lit_corr_flag", out_corrected, 1);
        cmp("lit_corr_errc", err_cnt_c, 1);

        // clean transaction breaks the streak, then three in a row retire lane C
        step(1, 'h03, 'h03, 'h03, 1, 0);
        step(1, 'h01, 'h01, 'h11, 1, 0);
        step(1, 'h02, 'h02, 'h12, 1, 0);
        cmp("lit_not_yet_faulty", lane_faulty, 0);
        step(1, 'h04, 'h04, 'h1F, 1, 0);
        cmp("lit_faulty_c", lane_faulty, 3'b100);
        cmp("lit_errc_4", err_cnt_c, 4);

        // DMR disagreement
        step(1, 'h03, 'h07, 'h07, 1, 0);
        cmp("lit_dmr_sum", out_sum, 3);
        cmp("lit_dmr_unc", out_uncorrectable, 1);
        cmp("lit_dmr_erra", err_cnt_a, 1);
        cmp("lit_dmr_errb", err_cnt_b, 1);

        // clear together with an accepted transaction
        step(1, 'h02, 'h02, 'h09, 1, 1);
        cmp("lit_clr_sum", out_sum, 2);
        cmp("lit_clr_faulty", lane_faulty, 0);
        cmp("lit_clr_erra", err_cnt_a, 0);

        // streak interrupted by a clean word: no retirement
        step(1, 'h01, 'h01, 'h00, 1, 0);
        step(1, 'h01, 'h01, 'h00, 1, 0);
        step(1, 'h01, 'h01, 'h01, 1, 0);
        step(1, 'h01, 'h01, 'h00, 1, 0);
        step(1, 'h01, 'h01, 'h00, 1, 0);
        cmp("lit_streak_faulty", lane_faulty, 0);
        cmp("lit_streak_errc", err_cnt_c, 4);

        // all three lanes disagree bitwise: simultaneous hits retire lane A only
        step(1, 'h01, 'h02, 'h04, 1, 1);
        for (int k = 0; k < 3; k++) step(1, 'h01, 'h02, 'h04, 1, 0);
        cmp("lit_tie_faulty", lane_faulty, 3'b001);
        step(0, 0, 0, 0, 1, 1);

        // backpressure: accept once, then stall
        step(1, 'h06, 'h06, 'h06, 0, 0);
        held = out_sum;
        for (int k = 0; k < 3; k++) begin
            step(1, 'h09, 'h09, 'h09, 0, 0);
            cmp("lit_stall_ready", in_ready, 0);
            cmp("lit_stall_sum", out_sum, held);
        end
        step(1, 'h0B, 'h0B, 'h0B, 1, 0);
        cmp("lit_release_valid", out_valid, 1);
        cmp("lit_release_sum", out_sum, 'hB);

        // randomized traffic, lane C error-prone so DMR is exercised
        for (int n = 0; n < 3000; n++) begin
            base = $urandom_range(0, 31);
            wa = base; wb = base; wc = base;
            r = $urandom_range(0, 9);
            if (r < 4) wc = base ^ $urandom_range(1, 31);
            else if (r == 4) wa = base ^ $urandom_range(1, 31);
            else if (r == 5) wb = base ^ $urandom_range(1, 31);
            else if (r == 6) begin
                wa = base ^ $urandom_range(1, 31);
                wb = base ^ $urandom_range(1, 31);
            end
            step($urandom_range(0, 3) != 0, wa, wb, wc,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
        end

        // asynchronous reset while a result is pending
        step(1, 'h0C, 'h0C, 'h0C, 0, 0);
        cmp("lit_pending_valid", out_valid, 1);
        async_reset();
        step(0, 0, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmr_sum_voter.md
Name: tmr_sum_voter

Overview:
- Downstream of three redundant 4-bit ripple-carry adder slices.
- Registers a bitwise-majority-voted {cout, sum} result and flags corrected or uncorrectable errors.
- Tracks persistent per-lane faults and degrades from triple to dual redundancy when a lane repeatedly disagrees.
- Output goes to the result consumer over a valid/ready handshake.

Parameters:
- WIDTH, 4, sum width of each adder lane.
- FAIL_LIMIT, 3, consecutive mismatching transactions before a lane is marked faulty (1..15).
- CNT_W, 8, width of each saturating per-lane error counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  lane results valid.
- in_ready  output  1  block can accept a transaction.
- sum_a, sum_b, sum_c  input  WIDTH  lane A/B/C sum.
- cout_a, cout_b, cout_c  input  1  lane A/B/C carry out.
- clear_faults  input  1  one-cycle pulse that returns the block to full redundancy.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  voted sum.
- out_cout  output  1  voted carry.
- out_corrected  output  1  at least one lane disagreed and the error was outvoted.
- out_uncorrectable  output  1  healthy lanes disagreed in DMR mode.
- lane_faulty  output  3  bit0=A, bit1=B, bit2=C; set when a lane is marked faulty.
- err_cnt_a, err_cnt_b, err_cnt_c  output  CNT_W  saturating mismatch counts per lane.

Behaviour:
- Reset (async, rst_n=0): every output register is 0.
  - Covers out_valid, out_sum, out_cout, out_corrected, out_uncorrectable, lane_faulty and all err_cnt_*.
  - Internal 4-bit consecutive counters are 0; state is TMR.
  - Reset mid-transaction drops the pending result.
- Lane word Wx = {cout_x, sum_x}, WIDTH+1 bits.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An input is accepted when in_valid && in_ready.
  - Latency is 1 cycle: out_valid rises on the edge that accepts the input.
  - Output fields hold stable while out_valid && !out_ready.
  - out_valid clears when out_ready=1 and no new input is accepted that cycle.
  - Back-to-back throughput is 1 per cycle when out_ready is held at 1.
- State TMR (lane_faulty==0):
  - V = bitwise majority (Wa&Wb)|(Wa&Wc)|(Wb&Wc).
  - Lane x mismatches if Wx != V.
  - out_corrected = any mismatch; out_uncorrectable = 0.
  - Per accepted transaction, each mismatching lane increments its err_cnt (saturating at 2^CNT_W-1) and its consecutive counter.
  - Each matching lane clears its consecutive counter.
  - If one or more consecutive counters reach FAIL_LIMIT on the same accept, only the lowest-index such lane is marked faulty; all consecutive counters clear.
  - Transition to DMR(x) on the next cycle.
- State DMR (exactly one lane faulty):
  - The faulty lane is ignored.
  - If the two healthy lanes are equal: V = that word, flags = 0.
  - If they differ: V = the lower-index healthy lane word, out_uncorrectable = 1, out_corrected = 0, and both healthy err_cnt values increment.
  - No further lanes are marked faulty; consecutive counters are held at 0.
  - The block remains in DMR until clear_faults or reset.
- clear_faults:
  - On the next edge: state becomes TMR, lane_faulty = 0, and all consecutive counters and err_cnt values become 0.
  - A transaction accepted in the same cycle is voted using the pre-clear state.
  - Its counter and fault updates are discarded because clear has priority.
  - Its output flags are delivered normally.
- lane_faulty is a registered output that changes only on the edge that marks a lane or clears faults.

Test Plan:
- Reset, then drive all lanes {0,4'hA} with out_ready=1 → next cycle out_valid=1, out_sum=4'hA, out_cout=0, out_corrected=0, all err_cnt=0.
- Lanes A={0,4'h5}, B={0,4'h5}, C={1,4'h4} → out_sum=4'h5, out_cout=0, out_corrected=1, err_cnt_c=1, lane_faulty=0.
- Three consecutive transactions with lane C wrong, FAIL_LIMIT=3 → lane_faulty=3'b100 after the third accept; a fourth transaction with A=4'h3, B=4'h7 → out_sum=4'h3, out_uncorrectable=1, err_cnt_a=err_cnt_b=1.
- Hold out_ready=0 for 4 cycles with in_valid=1 → in_ready=0 after the first accept, output fields stable; raise out_ready → the next input is accepted in the same cycle and out_valid stays 1.
- Lane C wrong twice, then all lanes correct, then C wrong twice → no lane is marked faulty (consecutive counter reset); err_cnt_c=4.
- In DMR(C), pulse clear_faults together with an accepted transaction → that result is still delivered; next cycle lane_faulty=0, all err_cnt=0, state TMR. Assert rst_n=0 while out_valid=1 → out_valid=0 immediately, with no clock edge needed.
